// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: owns PC, IR, MBR, AC.
// Optional CPU_SINGLE_STEP_EN adds a step input and a STEP_WAIT pause after each instruction.
module acc_cpu_sequencer #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 8,
    parameter logic [3:0]  ALU_ADD    = 4'h3,
    parameter logic [3:0]  ALU_SUB    = 4'h4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef CPU_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_mode,
    input  logic [DATA_WIDTH-1:0] alu_s,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic                  busy,
    output logic                  halted
);

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_F4,
        S_E1,
        S_E2,
        S_E3,
        S_HALTED
`ifdef CPU_SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] pc_next;
    // Only the opcode and skip-condition fields of IRA are ever consumed.
    logic [3:0]            ira_op_reg;
    logic [1:0]            ira_cc_reg;
    logic [DATA_WIDTH-1:0] irb_reg;
    logic [DATA_WIDTH-1:0] mbr_reg;
    logic [DATA_WIDTH-1:0] ac_reg;
    logic                  skip_take;
    logic                  exec_done;

    assign alu_a  = ac_reg;
    assign alu_b  = mbr_reg;
    assign pc_out = pc_reg;
    assign ac_out = ac_reg;

    // AC is treated as two's complement for the skip test.
    always_comb begin
        skip_take = 1'b0;
        case (ira_cc_reg)
            2'b00:   skip_take = ac_reg[DATA_WIDTH-1];
            2'b01:   skip_take = (ac_reg == '0);
            2'b10:   skip_take = (ac_reg != '0) && !ac_reg[DATA_WIDTH-1];
            default: skip_take = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_reg;
        case (state_reg)
            S_F2, S_F4: pc_next = pc_reg + ADDR_WIDTH'(1);
            S_E1: begin
                if (ira_op_reg == OP_SKIP && skip_take)
                    pc_next = pc_reg + ADDR_WIDTH'(2);
                else if (ira_op_reg == OP_JUMP)
                    pc_next = ADDR_WIDTH'(irb_reg);
            end
            default: ;
        endcase
    end

    // High in the last execute cycle of every instruction that returns to fetch.
    always_comb begin
        exec_done = 1'b0;
        case (state_reg)
            S_E1:    exec_done = !(ira_op_reg inside {OP_LOAD, OP_ADD, OP_SUB, OP_HALT});
            S_E2:    exec_done = (ira_op_reg == OP_LOAD);
            S_E3:    exec_done = 1'b1;
            default: exec_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            pc_reg     <= '0;
            ira_op_reg <= '0;
            ira_cc_reg <= '0;
            irb_reg    <= '0;
            mbr_reg    <= '0;
            ac_reg     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            alu_mode   <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            mem_oe <= 1'b0;
            pc_reg <= pc_next;

            // Memory strobes are registered: each transition sets up the next state's bus cycle.
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_F1;
                        busy      <= 1'b1;
                        mem_addr  <= pc_next;
                        mem_cs    <= 1'b1;
                        mem_oe    <= 1'b1;
                    end
                end
                S_F1: state_reg <= S_F2;
                S_F2: begin
                    ira_op_reg <= mem_rdata[7:4];
                    ira_cc_reg <= mem_rdata[1:0];
                    state_reg  <= S_F3;
                    mem_addr   <= pc_next;
                    mem_cs     <= 1'b1;
                    mem_oe     <= 1'b1;
                end
                S_F3: state_reg <= S_F4;
                S_F4: begin
                    irb_reg   <= mem_rdata;
                    state_reg <= S_E1;
                    if (ira_op_reg inside {OP_LOAD, OP_ADD, OP_SUB}) begin
                        mem_addr <= ADDR_WIDTH'(mem_rdata);
                        mem_cs   <= 1'b1;
                        mem_oe   <= 1'b1;
                    end else if (ira_op_reg == OP_STORE) begin
                        mem_addr  <= ADDR_WIDTH'(mem_rdata);
                        mem_wdata <= ac_reg;
                        mem_cs    <= 1'b1;
                        mem_we    <= 1'b1;
                    end
                end
                S_E1: begin
                    if (ira_op_reg == OP_HALT) begin
                        state_reg <= S_HALTED;
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                    end else if (ira_op_reg == OP_CLEAR) begin
                        ac_reg <= '0;
                    end else if (ira_op_reg inside {OP_LOAD, OP_ADD, OP_SUB}) begin
                        state_reg <= S_E2;
                    end
                end
                S_E2: begin
                    if (ira_op_reg == OP_LOAD) begin
                        ac_reg <= mem_rdata;
                    end else begin
                        mbr_reg   <= mem_rdata;
                        alu_mode  <= (ira_op_reg == OP_SUB) ? ALU_SUB : ALU_ADD;
                        state_reg <= S_E3;
                    end
                end
                S_E3: ac_reg <= alu_s;
                S_HALTED: ;
`ifdef CPU_SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (step) begin
                        state_reg <= S_F1;
                        mem_addr  <= pc_next;
                        mem_cs    <= 1'b1;
                        mem_oe    <= 1'b1;
                    end
                end
`endif
                default: state_reg <= S_IDLE;
            endcase

            if (exec_done) begin
`ifdef CPU_SINGLE_STEP_EN
                state_reg <= S_STEP_WAIT;
`else
                state_reg <= S_F1;
                mem_addr  <= pc_next;
                mem_cs    <= 1'b1;
                mem_oe    <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Directed bench for acc_cpu_sequencer with a behavioural synchronous RAM and combinational ALU.
module tb_acc_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_cs, mem_we, mem_oe;
    logic [7:0] alu_a, alu_b, alu_s;
    logic [3:0] alu_mode;
    logic [7:0] pc_out, ac_out;
    logic       busy, halted;
`ifdef CPU_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    always #5 clk = ~clk;

    acc_cpu_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CPU_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_s(alu_s),
        .pc_out(pc_out), .ac_out(ac_out), .busy(busy), .halted(halted)
    );

    // RAM with a bench-side load port used only while the DUT is held in reset.
    logic [7:0] mem [0:255];
    logic       load_en = 1'b0;
    logic [7:0] load_addr = 8'h00, load_data = 8'h00;
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
    end

    always_comb begin
        alu_s = 8'h00;
        if (alu_mode == 4'h3) alu_s = alu_a + alu_b;
        else if (alu_mode == 4'h4) alu_s = alu_a - alu_b;
    end

    int         wr_count = 0;
    logic [7:0] wr_addr_last = 8'h00, wr_data_last = 8'h00;
    int         rd_n = 0;
    logic [7:0] rd_log [0:4095];
    int         clash = 0;
    always @(negedge clk) begin
        if (mem_cs && mem_we) begin
            wr_count     <= wr_count + 1;
            wr_addr_last <= mem_addr;
            wr_data_last <= mem_wdata;
        end
        if (mem_cs && mem_oe) begin
            rd_log[rd_n & 4095] <= mem_addr;
            rd_n <= rd_n + 1;
        end
        if (mem_we && mem_oe) clash <= clash + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic begin_test();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
    endtask

    task automatic release_and_start();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_halted(input int max, output int n);
        n = 0;
        while (halted !== 1'b1 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++; if ({mem_addr, mem_wdata} !== 16'h0000) begin bad++; $display("FAIL reset_bus: got %h want 0000", {mem_addr, mem_wdata}); end
        total++; if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {mem_cs, mem_we, mem_oe}); end
        total++; if ({pc_out, ac_out, alu_a, alu_b} !== 32'h0) begin bad++; $display("FAIL reset_regs: got %h want 0", {pc_out, ac_out, alu_a, alu_b}); end
        total++; if ({alu_mode, busy, halted} !== 6'b0) begin bad++; $display("FAIL reset_status: got %b want 0", {alu_mode, busy, halted}); end
        start = 1'b0; rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        total++; if ({busy, mem_cs, pc_out} !== 10'h0) begin bad++; $display("FAIL reset_start_ignored: got %h want 0", {busy, mem_cs, pc_out}); end
    endtask

    task automatic test_basic();
        int n, w0, r0;
        begin_test();
        poke(8'h00, 8'h10); poke(8'h01, 8'h1C); poke(8'h02, 8'h30); poke(8'h03, 8'h1D);
        poke(8'h04, 8'h20); poke(8'h05, 8'h1F); poke(8'h06, 8'h70); poke(8'h07, 8'h00);
        poke(8'h1C, 8'h05); poke(8'h1D, 8'h03);
        w0 = wr_count;
        release_and_start();
        run_until_halted(200, n);
        total++; if (n !== 23) begin bad++; $display("FAIL basic_cycles: got %0d want 23", n); end
        total++; if ({halted, busy} !== 2'b10) begin bad++; $display("FAIL basic_status: got %b want 10", {halted, busy}); end
        total++; if (pc_out !== 8'h08) begin bad++; $display("FAIL basic_pc: got %h want 08", pc_out); end
        total++; if (ac_out !== 8'h08) begin bad++; $display("FAIL basic_ac: got %h want 08", ac_out); end
        total++; if (wr_count - w0 !== 1) begin bad++; $display("FAIL basic_write_count: got %0d want 1", wr_count - w0); end
        total++; if ({wr_addr_last, wr_data_last} !== 16'h1F08) begin bad++; $display("FAIL basic_write: got %h want 1f08", {wr_addr_last, wr_data_last}); end
        total++; if (mem[8'h1F] !== 8'h08) begin bad++; $display("FAIL basic_mem1f: got %h want 08", mem[8'h1F]); end
        total++; if ({alu_mode, alu_a, alu_b} !== 20'h30803) begin bad++; $display("FAIL basic_alu: got %h want 30803", {alu_mode, alu_a, alu_b}); end
        r0 = rd_n;
        repeat (4) @(posedge clk); #1;
        total++; if ({halted, pc_out} !== 9'h108 || rd_n !== r0) begin bad++; $display("FAIL basic_halt_hold: got %h reads %0d want 108 reads 0", {halted, pc_out}, rd_n - r0); end
    endtask

    task automatic test_sub_skip();
        int n, w0;
        begin_test();
        poke(8'h00, 8'h10); poke(8'h01, 8'h10); poke(8'h02, 8'h40); poke(8'h03, 8'h11);
        poke(8'h04, 8'h80); poke(8'h06, 8'hA0); poke(8'h08, 8'h82);
        poke(8'h0A, 8'h20); poke(8'h0B, 8'h1F); poke(8'h0C, 8'h70);
        poke(8'h10, 8'h01); poke(8'h11, 8'h02);
        w0 = wr_count;
        release_and_start();
        run_until_halted(300, n);
        total++; if (n !== 33) begin bad++; $display("FAIL sub_cycles: got %0d want 33", n); end
        total++; if (ac_out !== 8'hFF) begin bad++; $display("FAIL sub_wrap_ac: got %h want ff", ac_out); end
        total++; if (mem[8'h1F] !== 8'hFF || wr_count - w0 !== 1) begin bad++; $display("FAIL sub_store: got %h/%0d want ff/1", mem[8'h1F], wr_count - w0); end
        total++; if (pc_out !== 8'h0E) begin bad++; $display("FAIL sub_pc: got %h want 0e", pc_out); end
        total++; if (alu_mode !== 4'h4) begin bad++; $display("FAIL sub_mode: got %h want 4", alu_mode); end
    endtask

    task automatic test_fib();
        int n, w0;
        begin_test();
        poke(8'h00, 8'h10); poke(8'h01, 8'h1C); poke(8'h02, 8'h30); poke(8'h03, 8'h1D);
        poke(8'h04, 8'h20); poke(8'h05, 8'h1F); poke(8'h06, 8'h10); poke(8'h07, 8'h1D);
        poke(8'h08, 8'h20); poke(8'h09, 8'h1C); poke(8'h0A, 8'h10); poke(8'h0B, 8'h1F);
        poke(8'h0C, 8'h20); poke(8'h0D, 8'h1D); poke(8'h0E, 8'h10); poke(8'h0F, 8'h1E);
        poke(8'h10, 8'h40); poke(8'h11, 8'h1B); poke(8'h12, 8'h20); poke(8'h13, 8'h1E);
        poke(8'h14, 8'h81); poke(8'h16, 8'h90); poke(8'h18, 8'h70);
        poke(8'h1B, 8'h01); poke(8'h1C, 8'h01); poke(8'h1E, 8'h0A);
        w0 = wr_count;
        release_and_start();
        run_until_halted(2000, n);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL fib_halted: got %b want 1", halted); end
        total++; if (n !== 680) begin bad++; $display("FAIL fib_cycles: got %0d want 680", n); end
        total++; if (mem[8'h1F] !== 8'h37) begin bad++; $display("FAIL fib_sum: got %h want 37", mem[8'h1F]); end
        total++; if ({mem[8'h1C], mem[8'h1D], mem[8'h1E]} !== 24'h223700) begin bad++; $display("FAIL fib_vars: got %h want 223700", {mem[8'h1C], mem[8'h1D], mem[8'h1E]}); end
        total++; if (wr_count - w0 !== 40) begin bad++; $display("FAIL fib_writes: got %0d want 40", wr_count - w0); end
        total++; if ({pc_out, ac_out} !== 16'h1A00) begin bad++; $display("FAIL fib_pc_ac: got %h want 1a00", {pc_out, ac_out}); end
    endtask

    task automatic test_pc_wrap();
        int r0;
        logic [39:0] seq;
        begin_test();
        poke(8'h00, 8'h90); poke(8'h01, 8'hFE);
        r0 = rd_n;
        release_and_start();
        repeat (12) @(posedge clk); #1;
        seq = {rd_log[r0 & 4095], rd_log[(r0 + 1) & 4095], rd_log[(r0 + 2) & 4095], rd_log[(r0 + 3) & 4095], rd_log[(r0 + 4) & 4095]};
        total++; if (seq !== 40'h0001FEFF00) begin bad++; $display("FAIL wrap_nop_fetch: got %h want 0001feff00", seq); end
        total++; if ({busy, halted} !== 2'b10) begin bad++; $display("FAIL wrap_nop_status: got %b want 10", {busy, halted}); end
        begin_test();
        poke(8'h00, 8'h90); poke(8'h01, 8'hFC); poke(8'hFC, 8'h81); poke(8'hFE, 8'h70);
        r0 = rd_n;
        release_and_start();
        repeat (12) @(posedge clk); #1;
        seq = {rd_log[r0 & 4095], rd_log[(r0 + 1) & 4095], rd_log[(r0 + 2) & 4095], rd_log[(r0 + 3) & 4095], rd_log[(r0 + 4) & 4095]};
        total++; if (seq !== 40'h0001FCFD00) begin bad++; $display("FAIL wrap_skip_fetch: got %h want 0001fcfd00", seq); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL wrap_skip_halted: got %b want 0", halted); end
    endtask

    task automatic test_reset_mid_store();
        int n;
        begin_test();
        poke(8'h00, 8'h10); poke(8'h01, 8'h1C); poke(8'h02, 8'h20); poke(8'h03, 8'h1F);
        poke(8'h04, 8'h70); poke(8'h1C, 8'h5A);
        release_and_start();
        n = 0;
        while (mem_we !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (mem_we !== 1'b1 || n !== 10) begin bad++; $display("FAIL store_reach_e1: got we=%b after %0d want we=1 after 10", mem_we, n); end
        total++; if ({mem_addr, mem_wdata} !== 16'h1F5A) begin bad++; $display("FAIL store_bus: got %h want 1f5a", {mem_addr, mem_wdata}); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if ({mem_we, mem_cs, mem_oe} !== 3'b000) begin bad++; $display("FAIL rst_store_strobes: got %b want 000", {mem_we, mem_cs, mem_oe}); end
        total++; if ({ac_out, pc_out, busy} !== 17'h0) begin bad++; $display("FAIL rst_store_regs: got %h want 0", {ac_out, pc_out, busy}); end
        repeat (3) @(posedge clk); #1;
        total++; if ({busy, mem_cs, halted} !== 3'b000) begin bad++; $display("FAIL rst_store_idle: got %b want 000", {busy, mem_cs, halted}); end
    endtask

    task automatic test_bus_rules();
        total++; if (clash !== 0) begin bad++; $display("FAIL we_oe_clash: got %0d want 0", clash); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_skip();
        test_fib();
        test_pc_wrap();
        test_reset_mid_store();
        test_bus_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
